// File: rtl/evm_pkg.sv
// Shared constants, FSM state encoding and the candidate encoder for the EVM ballot front end.
package evm_pkg;

   localparam int unsigned NUM_CAND = 4;
   localparam int unsigned CAND_W   = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      DEBOUNCE = 3'd2,
      CAST     = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   function automatic logic [CAND_W-1:0] onehot2code(input logic [NUM_CAND-1:0] oh);
      logic [CAND_W-1:0] code;
      code = '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
         if (oh[i]) code = CAND_W'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/evm_ballot_unit_if.sv
// Voter-side bus of the ballot unit: officer arm, raw buttons in; vote, status and count out.
interface evm_ballot_unit_if #(
   parameter int unsigned CNT_W = 16
) ();
   import evm_pkg::*;

   logic                ballot_en;
   logic [NUM_CAND-1:0] btn;
   logic [CAND_W-1:0]   s;
   logic                vote_valid;
   logic                ready;
   logic                err;
   logic                timeout;
   logic [CNT_W-1:0]    ballots;

   modport master (
      output ballot_en, btn,
      input  s, vote_valid, ready, err, timeout, ballots
   );

   modport slave (
      input  ballot_en, btn,
      output s, vote_valid, ready, err, timeout, ballots
   );
endinterface

// File: rtl/evm_btn_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous button inputs.
module evm_btn_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end
endmodule

// File: rtl/evm_ballot_unit.sv
// Ballot FSM: arm, debounce one candidate, strobe one vote, lock until re-armed.
// Optional armed-window expiry is built when BALLOT_TIMEOUT_EN is defined.
module evm_ballot_unit
   import evm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   evm_ballot_unit_if.slave  bus
);
   state_t              state, state_nx;
   logic [NUM_CAND-1:0] bs, cand, cand_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx, ballots_q;
   logic                err_blk, err_blk_nx, err_nx, err_q, vv_q;
   logic [CAND_W-1:0]   s_q;
   logic                bs_multi, bs_zero;

   if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("evm_ballot_unit: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
   end

   evm_btn_sync #(.WIDTH(NUM_CAND)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (bus.btn),
      .dout (bs)
   );

   assign bs_zero  = (bs == '0);
   assign bs_multi = ((bs & (bs - NUM_CAND'(1))) != '0);

`ifdef BALLOT_TIMEOUT_EN
   logic [CNT_W-1:0] tcnt, tcnt_nx;
   logic             to_nx, to_q;
`endif

   always_comb begin
      state_nx   = state;
      cand_nx    = cand;
      cnt_nx     = cnt;
      err_blk_nx = err_blk;
      err_nx     = 1'b0;
      unique case (state)
         IDLE: begin
            err_blk_nx = 1'b0;
            if (bus.ballot_en) begin
               state_nx = ARMED;
               cnt_nx   = '0;
            end
         end
         ARMED: begin
            if (bs_zero) begin
               err_blk_nx = 1'b0;
            end else if (bs_multi) begin
               // one ERR per multi-press episode; re-enabled once all buttons are released
               err_nx     = !err_blk;
               err_blk_nx = 1'b1;
            end else begin
               cand_nx  = bs;
               cnt_nx   = CNT_W'(1);
               state_nx = (DEBOUNCE_CYCLES <= 1) ? CAST : DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (bs == cand) begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt_nx >= CNT_W'(DEBOUNCE_CYCLES)) state_nx = CAST;
            end else begin
               cnt_nx   = '0;
               state_nx = ARMED;
            end
         end
         CAST:    state_nx = RELEASE;
         RELEASE: if (bs_zero) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
`ifdef BALLOT_TIMEOUT_EN
      // expiry overrides whatever the case above chose, including a due CAST
      tcnt_nx = '0;
      to_nx   = 1'b0;
      if (state == ARMED || state == DEBOUNCE) begin
         if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            err_nx   = 1'b0;
            to_nx    = 1'b1;
         end else begin
            tcnt_nx = tcnt + CNT_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         err_blk   <= 1'b0;
         err_q     <= 1'b0;
         vv_q      <= 1'b0;
         s_q       <= '0;
         ballots_q <= '0;
      end else begin
         state   <= state_nx;
         cand    <= cand_nx;
         cnt     <= cnt_nx;
         err_blk <= err_blk_nx;
         err_q   <= err_nx;
         vv_q    <= (state_nx == CAST);
         if (state_nx == CAST) begin
            s_q <= onehot2code(cand_nx);
            if (ballots_q != '1) ballots_q <= ballots_q + CNT_W'(1);
         end
      end
   end

`ifdef BALLOT_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
         to_q <= 1'b0;
      end else begin
         tcnt <= tcnt_nx;
         to_q <= to_nx;
      end
   end
   assign bus.timeout = to_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.s          = s_q;
   assign bus.vote_valid = vv_q;
   assign bus.ready      = (state == ARMED) || (state == DEBOUNCE);
   assign bus.err        = err_q;
   assign bus.ballots    = ballots_q;
endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed bench for evm_ballot_unit (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_evm_ballot_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0, passed = 0;
   int   cyc = 0;
   int   vv_cnt = 0, vv_cyc = -1, err_cnt = 0, to_cnt = 0, to_cyc = -1;
   logic vv_prev = 1'b0, vv_consec = 1'b0;

   evm_ballot_unit_if #(.CNT_W(16)) bus ();

   evm_ballot_unit #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (20),
      .CNT_W          (16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // event monitor, sampled 2ns after each rising edge
   always @(posedge clk) begin
      #2;
      if (bus.vote_valid === 1'b1) begin
         vv_cnt++;
         vv_cyc = cyc;
         if (vv_prev) vv_consec = 1'b1;
      end
      vv_prev = (bus.vote_valid === 1'b1);
      if (bus.err === 1'b1) err_cnt++;
      if (bus.timeout === 1'b1) begin
         to_cnt++;
         to_cyc = cyc;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic arm(output int ac);
      ac = cyc;
      bus.ballot_en = 1'b1;
      step(1);
      bus.ballot_en = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.ballot_en = 1'b0;
      bus.btn = '0;
      step(3);
      checks++; if (bus.s !== 2'b00) $display("FAIL reset_s got %0d exp 0", bus.s); else passed++;
      checks++; if (bus.vote_valid !== 1'b0) $display("FAIL reset_vv got %b exp 0", bus.vote_valid); else passed++;
      checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.ready); else passed++;
      checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err); else passed++;
      checks++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", bus.timeout); else passed++;
      checks++; if (bus.ballots !== 16'd0) $display("FAIL reset_ballots got %0d exp 0", bus.ballots); else passed++;
      rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_basic;
      int ac, c0, v0;
      v0 = vv_cnt;
      arm(ac);
      checks++; if (bus.ready !== 1'b1) $display("FAIL basic_ready got %b exp 1", bus.ready); else passed++;
      c0 = cyc;
      bus.btn = 4'b0100;
      step(10);
      checks++; if (vv_cnt - v0 !== 1) $display("FAIL basic_votes got %0d exp 1", vv_cnt - v0); else passed++;
      checks++; if (vv_cyc !== c0 + 6) $display("FAIL basic_latency got %0d exp %0d", vv_cyc, c0 + 6); else passed++;
      checks++; if (bus.s !== 2'b10) $display("FAIL basic_s got %0d exp 2", bus.s); else passed++;
      checks++; if (bus.ballots !== 16'd1) $display("FAIL basic_ballots got %0d exp 1", bus.ballots); else passed++;
      checks++; if (bus.ready !== 1'b0) $display("FAIL basic_ready_after got %b exp 0", bus.ready); else passed++;
      bus.btn = '0;
      step(4);
   endtask

   task automatic test_hold_rearm;
      int ac, v0;
      v0 = vv_cnt;
      bus.btn = 4'b0010;
      arm(ac);
      step(10);
      arm(ac);
      step(10);
      checks++; if (vv_cnt - v0 !== 1) $display("FAIL hold_votes got %0d exp 1", vv_cnt - v0); else passed++;
      checks++; if (bus.ballots !== 16'd2) $display("FAIL hold_ballots got %0d exp 2", bus.ballots); else passed++;
      checks++; if (bus.s !== 2'b01) $display("FAIL hold_s got %0d exp 1", bus.s); else passed++;
      bus.btn = '0;
      step(4);
      arm(ac);
      bus.btn = 4'b0010;
      step(10);
      checks++; if (vv_cnt - v0 !== 2) $display("FAIL rearm_votes got %0d exp 2", vv_cnt - v0); else passed++;
      checks++; if (bus.ballots !== 16'd3) $display("FAIL rearm_ballots got %0d exp 3", bus.ballots); else passed++;
      bus.btn = '0;
      step(4);
   endtask

   task automatic test_multi;
      int ac, v0, e0;
      v0 = vv_cnt;
      e0 = err_cnt;
      arm(ac);
      bus.btn = 4'b1001;
      step(5);
      checks++; if (err_cnt - e0 !== 1) $display("FAIL multi_err_once got %0d exp 1", err_cnt - e0); else passed++;
      checks++; if (vv_cnt - v0 !== 0) $display("FAIL multi_novote got %0d exp 0", vv_cnt - v0); else passed++;
      checks++; if (bus.ready !== 1'b1) $display("FAIL multi_ready got %b exp 1", bus.ready); else passed++;
      bus.btn = '0;
      step(3);
      bus.btn = 4'b1100;
      step(4);
      checks++; if (err_cnt - e0 !== 2) $display("FAIL multi_err_again got %0d exp 2", err_cnt - e0); else passed++;
      bus.btn = 4'b0001;
      step(8);
      checks++; if (vv_cnt - v0 !== 1) $display("FAIL multi_vote got %0d exp 1", vv_cnt - v0); else passed++;
      checks++; if (bus.s !== 2'b00) $display("FAIL multi_s got %0d exp 0", bus.s); else passed++;
      checks++; if (bus.ballots !== 16'd4) $display("FAIL multi_ballots got %0d exp 4", bus.ballots); else passed++;
      bus.btn = '0;
      step(4);
   endtask

   task automatic test_bounce;
      int ac, v0, cs;
      v0 = vv_cnt;
      arm(ac);
      bus.btn = 4'b1000;
      step(2);
      bus.btn = '0;
      step(1);
      cs = cyc;
      bus.btn = 4'b1000;
      step(12);
      checks++; if (vv_cnt - v0 !== 1) $display("FAIL bounce_votes got %0d exp 1", vv_cnt - v0); else passed++;
      checks++; if (vv_cyc !== cs + 6) $display("FAIL bounce_latency got %0d exp %0d", vv_cyc, cs + 6); else passed++;
      checks++; if (bus.s !== 2'b11) $display("FAIL bounce_s got %0d exp 3", bus.s); else passed++;
      checks++; if (bus.ballots !== 16'd5) $display("FAIL bounce_ballots got %0d exp 5", bus.ballots); else passed++;
      bus.btn = '0;
      step(4);
   endtask

`ifdef BALLOT_TIMEOUT_EN
   task automatic test_timeout;
      int ac, v0, t0;
      v0 = vv_cnt;
      t0 = to_cnt;
      arm(ac);
      step(30);
      checks++; if (to_cnt - t0 !== 1) $display("FAIL timeout_pulse got %0d exp 1", to_cnt - t0); else passed++;
      checks++; if (to_cyc !== ac + 21) $display("FAIL timeout_cycle got %0d exp %0d", to_cyc, ac + 21); else passed++;
      checks++; if (bus.ready !== 1'b0) $display("FAIL timeout_ready got %b exp 0", bus.ready); else passed++;
      bus.btn = 4'b0100;
      step(10);
      checks++; if (vv_cnt - v0 !== 0) $display("FAIL timeout_novote got %0d exp 0", vv_cnt - v0); else passed++;
      checks++; if (bus.ballots !== 16'd5) $display("FAIL timeout_ballots got %0d exp 5", bus.ballots); else passed++;
      bus.btn = '0;
      step(4);
   endtask
`else
   task automatic test_no_timeout;
      int ac, v0, t0;
      v0 = vv_cnt;
      t0 = to_cnt;
      arm(ac);
      step(40);
      checks++; if (to_cnt - t0 !== 0) $display("FAIL notimeout_pulse got %0d exp 0", to_cnt - t0); else passed++;
      checks++; if (bus.ready !== 1'b1) $display("FAIL notimeout_ready got %b exp 1", bus.ready); else passed++;
      bus.btn = 4'b0100;
      step(10);
      checks++; if (vv_cnt - v0 !== 1) $display("FAIL notimeout_vote got %0d exp 1", vv_cnt - v0); else passed++;
      checks++; if (bus.ballots !== 16'd6) $display("FAIL notimeout_ballots got %0d exp 6", bus.ballots); else passed++;
      bus.btn = '0;
      step(4);
   endtask
`endif

   task automatic test_reset_abort;
      int ac, v0;
      v0 = vv_cnt;
      arm(ac);
      bus.btn = 4'b0010;
      step(3);
      checks++; if (bus.ready !== 1'b1) $display("FAIL abort_pre_ready got %b exp 1", bus.ready); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.ready !== 1'b0) $display("FAIL abort_ready got %b exp 0", bus.ready); else passed++;
      checks++; if (bus.ballots !== 16'd0) $display("FAIL abort_ballots got %0d exp 0", bus.ballots); else passed++;
      checks++; if (bus.s !== 2'b00) $display("FAIL abort_s got %0d exp 0", bus.s); else passed++;
      checks++; if (bus.err !== 1'b0 || bus.timeout !== 1'b0) $display("FAIL abort_flags got %b%b exp 00", bus.err, bus.timeout); else passed++;
      step(5);
      checks++; if (vv_cnt - v0 !== 0) $display("FAIL abort_novote got %0d exp 0", vv_cnt - v0); else passed++;
      checks++; if (bus.vote_valid !== 1'b0) $display("FAIL abort_vv got %b exp 0", bus.vote_valid); else passed++;
      bus.btn = '0;
      rst_n = 1'b1;
      step(4);
   endtask

   initial begin
      bus.ballot_en = 1'b0;
      bus.btn = '0;
      test_reset();
      test_basic();
      test_hold_rearm();
      test_multi();
      test_bounce();
`ifdef BALLOT_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_abort();
      checks++; if (vv_consec !== 1'b0) $display("FAIL vv_consecutive got %b exp 0", vv_consec); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
